// File: rtl/md_sched.sv
// Schedules MD ops into the MDU and tracks its busy window; issue is combinational, busy MUL/DIV_CYCLES.
// No queueing: an MD op meeting a busy MDU is held by stall_e/stall_d until the first idle cycle.
module md_sched #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       e_valid,
   input  logic [3:0] e_op,
   input  logic       d_md,
   output logic       mdu_start,
   output logic [3:0] mdu_op,
   output logic       busy,
   output logic       done,
   output logic       stall_e,
   output logic       stall_d
);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       e_md, is_mul, is_div, issue, busy_int;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      e_md      = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
      is_mul    = (e_op == 4'd1) || (e_op == 4'd2);
      is_div    = (e_op == 4'd3) || (e_op == 4'd4);
      busy_int  = (state != IDLE);
      issue     = e_md && !busy_int;
      case (state)
         IDLE: begin
            if (issue && is_mul) begin
               state_nxt = MUL;
               cnt_nxt   = 8'(MUL_CYCLES);
            end else if (issue && is_div) begin
               state_nxt = DIV;
               cnt_nxt   = 8'(DIV_CYCLES);
            end
         end
         MUL, DIV: begin
            if (cnt == 8'd1) begin
               state_nxt = IDLE;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
         end
      endcase
   end

   // Every output is masked while reset is held, including the purely combinational ones.
   always_comb begin
      mdu_start = 1'b0;
      mdu_op    = 4'd0;
      busy      = 1'b0;
      done      = 1'b0;
      stall_e   = 1'b0;
      stall_d   = 1'b0;
      if (reset) begin
         mdu_start = issue && (is_mul || is_div);
         mdu_op    = issue ? e_op : 4'd0;
         busy      = busy_int;
         done      = busy_int && (cnt == 8'd1);
         stall_e   = e_md && busy_int;
         stall_d   = d_md && (busy_int || mdu_start || stall_e);
      end
   end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: remaining-cycle model checked every cycle, plus directed literal checks.
module tb_md_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       e_valid = 1'b0;
   logic [3:0] e_op = 4'd0;
   logic       d_md = 1'b0;

   logic [1:0] mdu_start, busy, done, stall_e, stall_d;
   logic [3:0] mdu_op [2];

   int total = 0;
   int bad = 0;
   bit running = 1'b1;

   always #5 clk = ~clk;

   md_sched u0 (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .d_md(d_md),
      .mdu_start(mdu_start[0]), .mdu_op(mdu_op[0]), .busy(busy[0]), .done(done[0]),
      .stall_e(stall_e[0]), .stall_d(stall_d[0])
   );

   md_sched #(.MUL_CYCLES(1), .DIV_CYCLES(3)) u1 (
      .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .d_md(d_md),
      .mdu_start(mdu_start[1]), .mdu_op(mdu_op[1]), .busy(busy[1]), .done(done[1]),
      .stall_e(stall_e[1]), .stall_d(stall_d[1])
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: number of busy cycles still ahead of each instance.
   int rem [2] = '{0, 0};
   int mul_n [2] = '{5, 1};
   int div_n [2] = '{10, 3};

   function automatic bit is_md(input logic v, input logic [3:0] op);
      return v && op >= 1 && op <= 8;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem[0] = 0;
         rem[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (rem[i] > 0) rem[i] = rem[i] - 1;
            else if (is_md(e_valid, e_op) && e_op <= 2) rem[i] = mul_n[i];
            else if (is_md(e_valid, e_op) && e_op <= 4) rem[i] = div_n[i];
         end
      end
   end

   always @(negedge clk) begin
      if (running) begin
         for (int i = 0; i < 2; i++) begin
            bit em, bz, iss, st, se, sd, dn;
            logic [3:0] op;
            em  = is_md(e_valid, e_op);
            bz  = rem[i] != 0;
            iss = em && !bz;
            st  = iss && e_op <= 4;
            op  = iss ? e_op : 4'd0;
            dn  = rem[i] == 1;
            se  = em && bz;
            sd  = d_md && (bz || st || se);
            if (!reset) begin
               {bz, st, se, sd, dn} = '0;
               op = 4'd0;
            end
            chk($sformatf("m%0d.start", i), 8'(mdu_start[i]), 8'(st));
            chk($sformatf("m%0d.op", i), 8'(mdu_op[i]), 8'(op));
            chk($sformatf("m%0d.busy", i), 8'(busy[i]), 8'(bz));
            chk($sformatf("m%0d.done", i), 8'(done[i]), 8'(dn));
            chk($sformatf("m%0d.stall_e", i), 8'(stall_e[i]), 8'(se));
            chk($sformatf("m%0d.stall_d", i), 8'(stall_d[i]), 8'(sd));
         end
      end
   end

   task automatic step(input logic v, input logic [3:0] op, input logic dm);
      @(posedge clk);
      #1;
      e_valid = v;
      e_op    = op;
      d_md    = dm;
      #1;
   endtask

   initial begin
      // Reset held with a request present: everything stays 0.
      repeat (2) begin
         step(1, 4'd1, 1);
         chk("rst.start", 8'(mdu_start[0]), 0);
         chk("rst.op", 8'(mdu_op[0]), 0);
         chk("rst.stall_d", 8'(stall_d[0]), 0);
         chk("rst.busy", 8'(busy[0]), 0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rel.start", 8'(mdu_start[0]), 1);
      chk("rel.op", 8'(mdu_op[0]), 1);
      chk("rel.stall_d", 8'(stall_d[0]), 1);
      for (int k = 1; k <= 6; k++) begin
         step(0, 4'd0, 1);
         chk($sformatf("mul.busy%0d", k), 8'(busy[0]), 8'(k <= 5));
         chk($sformatf("mul.done%0d", k), 8'(done[0]), 8'(k == 5));
         chk($sformatf("mul.stall_d%0d", k), 8'(stall_d[0]), 8'(k <= 5));
      end

      // div followed by mflo held in E for the whole divide
      step(1, 4'd3, 0);
      chk("div.start", 8'(mdu_start[0]), 1);
      for (int k = 1; k <= 10; k++) begin
         step(1, 4'd6, 0);
         chk($sformatf("mflo.stall_e%0d", k), 8'(stall_e[0]), 1);
         chk($sformatf("mflo.op%0d", k), 8'(mdu_op[0]), 0);
      end
      step(1, 4'd6, 0);
      chk("mflo.issue_op", 8'(mdu_op[0]), 6);
      chk("mflo.issue_start", 8'(mdu_start[0]), 0);
      chk("mflo.issue_stall", 8'(stall_e[0]), 0);

      // mthi in idle
      step(1, 4'd7, 1);
      chk("mthi.op", 8'(mdu_op[0]), 7);
      chk("mthi.start", 8'(mdu_start[0]), 0);
      chk("mthi.stall_d", 8'(stall_d[0]), 0);
      step(0, 4'd0, 1);
      chk("mthi.busy", 8'(busy[0]), 0);

      // single-cycle multiply on the second instance
      step(1, 4'd2, 0);
      chk("m1.start", 8'(mdu_start[1]), 1);
      step(0, 4'd0, 0);
      chk("m1.busy", 8'(busy[1]), 1);
      chk("m1.done", 8'(done[1]), 1);
      step(0, 4'd0, 0);
      chk("m1.idle", 8'(busy[1]), 0);
      repeat (4) step(0, 4'd0, 0);
      chk("mul2.idle", 8'(busy[0]), 0);

      // divu aborted by reset in busy cycle 4
      step(1, 4'd4, 0);
      chk("divu.op", 8'(mdu_op[0]), 4);
      repeat (4) step(0, 4'd0, 0);
      chk("divu.busy4", 8'(busy[0]), 1);
      #1 reset = 1'b0;
      #1;
      chk("abort.busy", 8'(busy[0]), 0);
      chk("abort.done", 8'(done[0]), 0);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      e_valid = 1'b1;
      e_op    = 4'd3;
      #1;
      chk("reissue.start", 8'(mdu_start[0]), 1);
      chk("reissue.op", 8'(mdu_op[0]), 3);
      repeat (12) step(0, 4'd0, 0);

      // non-issuing encodings
      step(1, 4'd12, 1);
      chk("op12.op", 8'(mdu_op[0]), 0);
      chk("op12.stall_d", 8'(stall_d[0]), 0);
      step(0, 4'd3, 1);
      chk("inval.op", 8'(mdu_op[0]), 0);
      chk("inval.start", 8'(mdu_start[0]), 0);
      step(0, 4'd0, 0);
      chk("inval.busy", 8'(busy[0]), 0);

      // random traffic with occasional reset pulses
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         e_valid = ($urandom_range(0, 3) != 0);
         e_op    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         d_md    = 1'($urandom_range(0, 1));
         if (!reset) reset = 1'b1;
         else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      end
      @(posedge clk);
      #1 running = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md_sched.md
# md_sched

Scheduler for the multiply/divide unit in the pipelined CPU, sitting in the E stage beside the MDU. It decides when an E-stage multiply/divide/HI-LO instruction may be issued to the MDU and drives the MDU's start pulse and opcode. It tracks the MDU's multi-cycle latency with its own state machine and counter. It generates the D-stage and E-stage stall requests used by the hazard unit.

## Interface

Parameters:

- MUL_CYCLES, default 5: busy cycles after a mult/multu issue (legal range 1..255).
- DIV_CYCLES, default 10: busy cycles after a div/divu issue (legal range 1..255).

Ports:

- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- e_valid  in  1  E-stage instruction is valid (not a bubble).
- e_op  in  4  E-stage MD opcode: 0 NOP, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 are treated as NOP.
- d_md  in  1  D-stage instruction is any MD opcode (1..8).
- mdu_start  out  1  one-cycle start pulse to the MDU (mult/multu/div/divu only).
- mdu_op  out  4  opcode presented to the MDU; 0 unless issuing this cycle.
- busy  out  1  MDU computation in progress.
- done  out  1  one-cycle pulse in the final busy cycle.
- stall_e  out  1  hold the E stage; the E-stage MD instruction cannot issue this cycle.
- stall_d  out  1  hold the D stage because of an MD structural hazard.

## Operation

- States: IDLE, MUL, DIV. There is an 8-bit down-counter `cnt`.
- e_md = e_valid & (e_op in 1..8). A value of 1..8 with e_valid=0 is ignored.
- issue = e_md & (state==IDLE). All issue logic is combinational in the same cycle.
- When issue is true, mdu_op = e_op. Otherwise mdu_op = 0.
- mdu_start = issue & (e_op in 1..4). mf/mt ops issue with mdu_start=0 and cause no state change.
- IDLE transitions:
  - issue of mult/multu: go to MUL, cnt <= MUL_CYCLES.
  - issue of div/divu: go to DIV, cnt <= DIV_CYCLES.
  - otherwise stay in IDLE.
- MUL/DIV behaviour:
  - cnt decrements every cycle.
  - When cnt==1: done=1, next state is IDLE, cnt <= 0.
- busy = (state != IDLE).
- stall_e = e_md & busy. While stall_e is high, mdu_op=0 and mdu_start=0. The instruction is re-evaluated each cycle and issues in the first IDLE cycle.
- stall_d = d_md & (busy | mdu_start | stall_e). An MD instruction never leaves D while a computation is pending or is starting this cycle.
- A non-MD instruction in E or D is never stalled by this block.
- A new op cannot be accepted while busy. No back-to-back overlap is possible. Any MD op in E while busy is held by stall_e.
- Reset (reset==0) acts asynchronously: state becomes IDLE and cnt becomes 0. All outputs are forced to 0 while reset is held, including the combinational outputs mdu_start, mdu_op and stalls.
- Reset mid-computation aborts it immediately. No done pulse is produced.
- Reset release has no effect on outputs until inputs present a request.

## Timing

- Reset values: mdu_start=0, mdu_op=0, busy=0, done=0, stall_e=0, stall_d=0.
- Multiply issued in cycle T (mdu_start=1 in T):
  - busy=1 in cycles T+1..T+MUL_CYCLES.
  - done=1 in T+MUL_CYCLES.
  - IDLE in T+MUL_CYCLES+1.
- Divide issued in cycle T follows the same pattern with DIV_CYCLES.
- An MD op in E at T+k (1≤k≤N) has stall_e=1 through T+N. It issues at T+N+1 with zero extra latency.
- stall_d is already 1 in the issue cycle T if d_md=1.
- mf/mt ops issued in IDLE complete in one cycle and produce no busy and no done.
- With MUL_CYCLES=1 or DIV_CYCLES=1: a single busy cycle in which done=1.

## Test plan

- Reset low with e_valid=1, e_op=1 → all outputs 0. Release reset; same inputs → mdu_start=1, mdu_op=1 in that cycle.
- mult issued at cycle 10, d_md=1 held → stall_d=1 in cycles 10..15, busy=1 in 11..15, done=1 in 15, stall_d=0 in 16.
- div at cycle 0, then mflo in E at cycle 1 → stall_e=1 in cycles 1..10, mdu_op=0 throughout, mflo issues (mdu_op=6, mdu_start=0) at cycle 11.
- mthi with e_valid=1 in IDLE → mdu_op=7, mdu_start=0, busy stays 0, stall_d=0 even with d_md=1.
- divu started, reset pulsed low at busy cycle 4 → busy=0 asynchronously, no done pulse, next div issues immediately after release.
- e_op=12 or e_valid=0 with e_op=3 → no issue, mdu_op=0, state stays IDLE.
